// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline sequencing controller.
package pipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUSH_C = 3'd1,
    ST_PUSH_I = 3'd2,
    ST_VEC    = 3'd3,
    ST_POP    = 3'd4,
    ST_RESUME = 3'd5
  } state_e;

  localparam int FD = 0;
  localparam int DE = 1;
  localparam int EM = 2;
  localparam int MW = 3;

  function automatic int pc_words(input int pc_w, input int data_w);
    return pc_w / data_w;
  endfunction

  // word_idx is never narrower than one bit, even for single-word PCs
  function automatic int widx_w(input int pc_w, input int data_w);
    int n;
    n = pc_words(pc_w, data_w);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// Datapath <-> sequencing controller bundle; master = datapath, slave = controller.
interface pipe_seq_ctrl_if #(
  parameter int STAGES     = 5,
  parameter int REG_ADDR_W = 3,
  parameter int PC_W       = 32,
  parameter int DATA_W     = 16
);
  import pipe_pkg::*;

  localparam int WIDX_W = widx_w(PC_W, DATA_W);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_use1;
  logic                  id_use2;
  logic                  ex_valid;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic                  redirect;
  logic                  call_req;
  logic                  ret_req;
  logic                  irq;
  logic                  stall_fe;
  logic                  bubble_de;
  logic [STAGES-1:0]     flush;
  logic                  push_en;
  logic                  pop_en;
  logic [WIDX_W-1:0]     word_idx;
  logic                  pc_load;
  logic                  vec_load;
  logic                  busy;
  logic                  irq_ack;

  modport master (
    output id_valid, id_src1, id_src2, id_use1, id_use2,
    output ex_valid, ex_mem_read, ex_dst, redirect, call_req, ret_req, irq,
    input  stall_fe, bubble_de, flush, push_en, pop_en, word_idx,
    input  pc_load, vec_load, busy, irq_ack
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_use1, id_use2,
    input  ex_valid, ex_mem_read, ex_dst, redirect, call_req, ret_req, irq,
    output stall_fe, bubble_de, flush, push_en, pop_en, word_idx,
    output pc_load, vec_load, busy, irq_ack
  );

endinterface

// File: rtl/pipe_hazard_det.sv
// Combinational load-use hazard detection and redirect flush generation.
module pipe_hazard_det #(
  parameter int STAGES       = 5,
  parameter int BRANCH_STAGE = 2,
  parameter int REG_ADDR_W   = 3
) (
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_src1,
  input  logic [REG_ADDR_W-1:0] i_id_src2,
  input  logic                  i_id_use1,
  input  logic                  i_id_use2,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_dst,
  input  logic                  i_redirect,
  output logic                  o_hz_stall,
  output logic                  o_bubble,
  output logic [STAGES-1:0]     o_flush
);

  localparam logic [STAGES-1:0] FLUSH_MASK = STAGES'((64'd1 << BRANCH_STAGE) - 64'd1);

  logic w_hz;

  assign w_hz = i_id_valid & i_ex_valid & i_ex_mem_read &
                ((i_id_use1 & (i_id_src1 == i_ex_dst)) |
                 (i_id_use2 & (i_id_src2 == i_ex_dst)));

  // a redirect discards the younger instruction anyway, so the hazard is moot
  assign o_hz_stall = w_hz & ~i_redirect;
  assign o_bubble   = w_hz & ~i_redirect;
  assign o_flush    = i_redirect ? FLUSH_MASK : '0;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: hazard/redirect lines plus call/return/irq PC-stack FSM.
//   state     | meaning
//   IDLE      | no sequence active; ret/call/irq sampled here
//   PUSH_C    | pushing return PC words for a call
//   PUSH_I    | pushing return PC words for an interrupt
//   VEC       | load interrupt vector, flush front end
//   POP       | popping PC words for RET/RTI
//   RESUME    | load popped PC, flush front end
module pipe_seq_ctrl
  import pipe_pkg::*;
#(
  parameter int STAGES       = 5,
  parameter int BRANCH_STAGE = 2,
  parameter int REG_ADDR_W   = 3,
  parameter int PC_W         = 32,
  parameter int DATA_W       = 16
) (
  input logic           clk,
  input logic           reset,
  pipe_seq_ctrl_if.slave bus
);

  localparam int                PC_WORDS   = pc_words(PC_W, DATA_W);
  localparam int                WIDX_W     = widx_w(PC_W, DATA_W);
  localparam logic [WIDX_W-1:0] LAST_IDX   = WIDX_W'(PC_WORDS - 1);
  localparam logic [STAGES-1:0] FLUSH_MASK = STAGES'((64'd1 << BRANCH_STAGE) - 64'd1);

  state_e            r_state;
  logic [WIDX_W-1:0] r_cnt;
  logic              r_irq_pend;
  logic              r_push_en, r_pop_en, r_pc_load, r_vec_load, r_busy, r_irq_ack, r_fsm_stall;
  logic [STAGES-1:0] r_fsm_flush;

  state_e            w_state_nxt;
  logic [WIDX_W-1:0] w_cnt_nxt;
  logic              w_last;
  logic              w_push_nxt, w_pop_nxt, w_pc_load_nxt, w_vec_load_nxt;
  logic              w_busy_nxt, w_irq_ack_nxt, w_stall_nxt;
  logic [STAGES-1:0] w_flush_nxt;
  logic              w_hz_stall, w_bubble;
  logic [STAGES-1:0] w_rd_flush;

  pipe_hazard_det #(
    .STAGES      (STAGES),
    .BRANCH_STAGE(BRANCH_STAGE),
    .REG_ADDR_W  (REG_ADDR_W)
  ) u_hazard (
    .i_id_valid   (bus.id_valid),
    .i_id_src1    (bus.id_src1),
    .i_id_src2    (bus.id_src2),
    .i_id_use1    (bus.id_use1),
    .i_id_use2    (bus.id_use2),
    .i_ex_valid   (bus.ex_valid),
    .i_ex_mem_read(bus.ex_mem_read),
    .i_ex_dst     (bus.ex_dst),
    .i_redirect   (bus.redirect),
    .o_hz_stall   (w_hz_stall),
    .o_bubble     (w_bubble),
    .o_flush      (w_rd_flush)
  );

  assign w_last = (r_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_irq_pend  <= 1'b0;
      r_push_en   <= 1'b0;
      r_pop_en    <= 1'b0;
      r_pc_load   <= 1'b0;
      r_vec_load  <= 1'b0;
      r_busy      <= 1'b0;
      r_irq_ack   <= 1'b0;
      r_fsm_stall <= 1'b0;
      r_fsm_flush <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      // entering PUSH_I consumes the pending request
      r_irq_pend  <= w_irq_ack_nxt ? 1'b0 : (r_irq_pend | bus.irq);
      r_push_en   <= w_push_nxt;
      r_pop_en    <= w_pop_nxt;
      r_pc_load   <= w_pc_load_nxt;
      r_vec_load  <= w_vec_load_nxt;
      r_busy      <= w_busy_nxt;
      r_irq_ack   <= w_irq_ack_nxt;
      r_fsm_stall <= w_stall_nxt;
      r_fsm_flush <= w_flush_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.ret_req)       w_state_nxt = ST_POP;
        else if (bus.call_req) w_state_nxt = ST_PUSH_C;
        else if (r_irq_pend)   w_state_nxt = ST_PUSH_I;
      end
      ST_PUSH_C: begin
        if (w_last) w_state_nxt = ST_IDLE;
        else        w_cnt_nxt   = r_cnt + WIDX_W'(1);
      end
      ST_PUSH_I: begin
        if (w_last) w_state_nxt = ST_VEC;
        else        w_cnt_nxt   = r_cnt + WIDX_W'(1);
      end
      ST_POP: begin
        if (w_last) w_state_nxt = ST_RESUME;
        else        w_cnt_nxt   = r_cnt + WIDX_W'(1);
      end
      ST_VEC, ST_RESUME: w_state_nxt = ST_IDLE;
      default:           w_state_nxt = ST_IDLE;
    endcase
  end

  // outputs are decoded from the next state so the registers line up with r_state
  always_comb begin
    w_push_nxt     = 1'b0;
    w_pop_nxt      = 1'b0;
    w_pc_load_nxt  = 1'b0;
    w_vec_load_nxt = 1'b0;
    w_busy_nxt     = 1'b0;
    w_irq_ack_nxt  = 1'b0;
    w_stall_nxt    = 1'b0;
    w_flush_nxt    = '0;
    case (w_state_nxt)
      ST_PUSH_C: begin
        w_push_nxt  = 1'b1;
        w_stall_nxt = 1'b1;
        w_busy_nxt  = 1'b1;
      end
      ST_PUSH_I: begin
        w_push_nxt    = 1'b1;
        w_stall_nxt   = 1'b1;
        w_busy_nxt    = 1'b1;
        w_irq_ack_nxt = (r_state == ST_IDLE);
      end
      ST_VEC: begin
        w_vec_load_nxt = 1'b1;
        w_flush_nxt    = FLUSH_MASK;
        w_busy_nxt     = 1'b1;
      end
      ST_POP: begin
        w_pop_nxt   = 1'b1;
        w_stall_nxt = 1'b1;
        w_busy_nxt  = 1'b1;
      end
      ST_RESUME: begin
        w_pc_load_nxt = 1'b1;
        w_flush_nxt   = FLUSH_MASK;
        w_busy_nxt    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.stall_fe  = w_hz_stall | r_fsm_stall;
  assign bus.bubble_de = w_bubble;
  assign bus.flush     = w_rd_flush | r_fsm_flush;
  assign bus.push_en   = r_push_en;
  assign bus.pop_en    = r_pop_en;
  assign bus.word_idx  = r_cnt;
  assign bus.pc_load   = r_pc_load;
  assign bus.vec_load  = r_vec_load;
  assign bus.busy      = r_busy;
  assign bus.irq_ack   = r_irq_ack;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench for pipe_seq_ctrl: stimulus queues expected output vectors, a monitor pops and compares.
module tb_pipe_seq_ctrl;

  logic clk;
  logic reset;
  logic strobe;
  int   checks;
  int   failures;

  logic [13:0] sb[$];

  pipe_seq_ctrl_if #(.STAGES(5), .REG_ADDR_W(3), .PC_W(32), .DATA_W(16)) bus ();

  pipe_seq_ctrl #(
    .STAGES(5), .BRANCH_STAGE(2), .REG_ADDR_W(3), .PC_W(32), .DATA_W(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {stall_fe, bubble_de, flush[4:0], push_en, pop_en, word_idx, pc_load, vec_load, busy, irq_ack}
  function automatic logic [13:0] mk(input logic st, input logic bub, input logic [4:0] fl,
                                     input logic pu, input logic po, input logic wi,
                                     input logic pl, input logic vl, input logic bz,
                                     input logic ak);
    return {st, bub, fl, pu, po, wi, pl, vl, bz, ak};
  endfunction

  localparam logic [13:0] ZERO = 14'd0;
  logic [13:0] e_hz, e_rd, e_c0, e_c1, e_p0, e_p1, e_res, e_i0, e_i1, e_vec;

  task automatic cyc();
    @(posedge clk);
    #1;
    strobe = 1'b0;
  endtask

  task automatic chk(input logic [13:0] rec);
    sb.push_back(rec);
    strobe = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [13:0] act;
    logic [13:0] exp_v;
    if (strobe || bus.busy === 1'b1 || bus.irq_ack === 1'b1) begin
      act = {bus.stall_fe, bus.bubble_de, bus.flush, bus.push_en, bus.pop_en, bus.word_idx,
             bus.pc_load, bus.vec_load, bus.busy, bus.irq_ack};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output t=%0t actual=%b required=none", $time, act);
      end else begin
        exp_v = sb.pop_front();
        if (act !== exp_v) begin
          failures++;
          $display("FAIL out_vec t=%0t actual=%b required=%b", $time, act, exp_v);
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    strobe   = 1'b0;
    reset    = 1'b1;
    bus.id_valid = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.id_use1 = 0; bus.id_use2 = 0;
    bus.ex_valid = 0; bus.ex_mem_read = 0; bus.ex_dst = 0; bus.redirect = 0;
    bus.call_req = 0; bus.ret_req = 0; bus.irq = 0;

    e_hz  = mk(1, 1, 5'b00000, 0, 0, 0, 0, 0, 0, 0);
    e_rd  = mk(0, 0, 5'b00011, 0, 0, 0, 0, 0, 0, 0);
    e_c0  = mk(1, 0, 5'b00000, 1, 0, 0, 0, 0, 1, 0);
    e_c1  = mk(1, 0, 5'b00000, 1, 0, 1, 0, 0, 1, 0);
    e_p0  = mk(1, 0, 5'b00000, 0, 1, 0, 0, 0, 1, 0);
    e_p1  = mk(1, 0, 5'b00000, 0, 1, 1, 0, 0, 1, 0);
    e_res = mk(0, 0, 5'b00011, 0, 0, 0, 1, 0, 1, 0);
    e_i0  = mk(1, 0, 5'b00000, 1, 0, 0, 0, 0, 1, 1);
    e_i1  = mk(1, 0, 5'b00000, 1, 0, 1, 0, 0, 1, 0);
    e_vec = mk(0, 0, 5'b00011, 0, 0, 0, 0, 1, 1, 0);

    // reset state
    cyc(); cyc();
    chk(ZERO);
    cyc(); reset = 1'b0; chk(ZERO);

    // load-use hazard patterns
    cyc(); bus.id_valid = 1; bus.ex_valid = 1; bus.ex_mem_read = 1;
           bus.id_src1 = 3; bus.id_use1 = 1; bus.ex_dst = 3; chk(e_hz);
    cyc(); bus.ex_dst = 4; chk(ZERO);
    cyc(); bus.id_use1 = 0; bus.id_src2 = 4; bus.id_use2 = 1; chk(e_hz);
    cyc(); bus.ex_mem_read = 0; chk(ZERO);
    cyc(); bus.ex_mem_read = 1; bus.id_valid = 0; chk(ZERO);

    // redirect overrides hazard
    cyc(); bus.id_valid = 1; bus.ex_dst = 3; bus.id_src1 = 3; bus.id_use1 = 1;
           bus.id_use2 = 0; bus.redirect = 1; chk(e_rd);
    cyc(); bus.redirect = 0; bus.id_valid = 0; bus.ex_valid = 0; bus.ex_mem_read = 0;
           bus.id_use1 = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.ex_dst = 0; chk(ZERO);

    // call: two push words, then idle
    cyc(); bus.call_req = 1; sb.push_back(e_c0); sb.push_back(e_c1);
    cyc(); bus.call_req = 0;
    cyc();
    cyc(); chk(ZERO);

    // irq arriving during POP is served after RESUME
    cyc(); bus.ret_req = 1; sb.push_back(e_p0); sb.push_back(e_p1); sb.push_back(e_res);
    cyc(); bus.ret_req = 0; bus.irq = 1;
    cyc(); bus.irq = 0;
    cyc();
    cyc(); sb.push_back(e_i0); sb.push_back(e_i1); sb.push_back(e_vec);
    cyc();
    cyc();
    cyc();
    cyc(); chk(ZERO);

    // ret beats call; call still high after RESUME starts a push
    cyc(); bus.ret_req = 1; bus.call_req = 1;
           sb.push_back(e_p0); sb.push_back(e_p1); sb.push_back(e_res);
           sb.push_back(e_c0); sb.push_back(e_c1);
    cyc(); bus.ret_req = 0;
    cyc();
    cyc();
    cyc();
    cyc(); bus.call_req = 0;
    cyc();
    cyc(); chk(ZERO);

    // reset during second PUSH_I word abandons the sequence and the re-pended irq
    cyc(); bus.irq = 1;
    cyc(); bus.irq = 0; sb.push_back(e_i0); sb.push_back(e_i1);
    cyc(); bus.irq = 1;
    cyc(); bus.irq = 0; reset = 1'b1;
    cyc(); reset = 1'b0; chk(ZERO);
    cyc(); chk(ZERO);
    cyc(); chk(ZERO);
    cyc(); chk(ZERO);

    cyc();
    cyc();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d_left required=0_left", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
Parametrised pipeline sequencing controller. It merges load-use hazard detection, redirect flushing and multi-word call/return/interrupt PC-stack sequencing into one block. It sits beside the fetch/decode/execute/memory/writeback datapath and drives its stall, bubble and flush lines. It generalises the fixed 5-stage, 2-half-word scheme to any stage count and any PC/data width ratio, and adds pending-interrupt queuing and a busy handshake.

Parameters:
STAGES, 5, number of pipeline registers; index 0 = FD, increasing toward WB
BRANCH_STAGE, 2, stage index where redirects resolve; flush covers indices 0..BRANCH_STAGE-1
REG_ADDR_W, 3, register address width
PC_W, 32, program counter width
DATA_W, 16, stack word width; PC_WORDS = PC_W/DATA_W, must be an integer >= 1

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
id_valid  in  1  decode stage holds a valid instruction
id_src1  in  REG_ADDR_W  decode source 1 address
id_src2  in  REG_ADDR_W  decode source 2 address
id_use1  in  1  decode instruction reads src1
id_use2  in  1  decode instruction reads src2
ex_valid  in  1  execute stage valid
ex_mem_read  in  1  execute instruction is a load
ex_dst  in  REG_ADDR_W  execute destination address
redirect  in  1  taken branch/jump resolved at BRANCH_STAGE
call_req  in  1  level request: push return PC
ret_req  in  1  level request: pop PC (RET/RTI)
irq  in  1  interrupt request, level
stall_fe  out  1  hold PC and FD register
bubble_de  out  1  insert NOP into DE register
flush  out  STAGES  per-stage flush
push_en  out  1  write one PC word to stack this cycle
pop_en  out  1  read one PC word from stack this cycle
word_idx  out  max(1,clog2(PC_WORDS))  word being pushed/popped; word 0 = least-significant
pc_load  out  1  load PC from popped value (1 cycle)
vec_load  out  1  load PC from interrupt vector (1 cycle)
busy  out  1  FSM not IDLE; requests are ignored while high
irq_ack  out  1  one-cycle pulse on interrupt acceptance

Behaviour:
- Load-use hazard (combinational): hz = id_valid & ex_valid & ex_mem_read & ((id_use1 & id_src1==ex_dst) | (id_use2 & id_src2==ex_dst)).
  - hz -> stall_fe=1 and bubble_de=1 in the same cycle.
- Redirect (combinational): flush[i]=1 for i<BRANCH_STAGE.
  - Redirect overrides hz: stall_fe=0, bubble_de=0.
- irq_pend register: set on any cycle with irq=1; cleared on entry to PUSH_I.
  - irq during busy stays pending and is served after return to IDLE.
- FSM states: IDLE, PUSH_C, PUSH_I, VEC, POP, RESUME. All FSM outputs are registered.
- IDLE: requests are sampled only here. Priority: ret_req > call_req > irq_pend.
  - ret_req -> POP.
  - call_req -> PUSH_C.
  - irq_pend -> PUSH_I, with irq_ack pulse on the transition cycle.
- PUSH_C/PUSH_I: push_en=1 and stall_fe=1 for exactly PC_WORDS cycles; word_idx counts 0..PC_WORDS-1.
  - Last word: PUSH_C -> IDLE; PUSH_I -> VEC.
- VEC: one cycle; vec_load=1, flush[BRANCH_STAGE-1:0]=1, stall_fe=0; then IDLE.
- POP: pop_en=1 and stall_fe=1 for PC_WORDS cycles; word_idx counts 0..PC_WORDS-1; then RESUME.
- RESUME: one cycle; pc_load=1, flush[BRANCH_STAGE-1:0]=1; then IDLE.
- busy=1 in every state except IDLE. stall_fe is the OR of hz-stall and FSM stall. flush is the OR of redirect flush and FSM flush.
- PC_WORDS=1: each push/pop phase lasts 1 cycle; word_idx stays 0.
- Reset values: state=IDLE, irq_pend=0, word counter=0.
  - Registered outputs push_en, pop_en, pc_load, vec_load, busy, irq_ack = 0.
  - Combinational outputs reduce to 0 when inputs are 0.
- Reset mid-sequence: IDLE on the next edge; partial push/pop abandoned; pending irq dropped.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding enum;
  - PC_WORDS and the word_idx width derivation function;
  - stage index constants FD=0, DE=1, EM=2, MW=3.
- One sub-module, pipe_hazard_det: the combinational hz/redirect logic.
- The FSM and irq_pend stay in the top.

Test Plan:
Defaults (STAGES=5, BRANCH_STAGE=2, PC_WORDS=2).
1. id_src1=3, id_use1=1, ex_mem_read=1, ex_dst=3, valids high -> stall_fe=1, bubble_de=1 same cycle; ex_dst=4 -> both 0.
2. Hazard of scenario 1 plus redirect=1 -> flush=5'b00011, stall_fe=0, bubble_de=0.
3. call_req pulse in IDLE -> push_en high 2 cycles with word_idx 0 then 1, busy high 2 cycles, then IDLE; no flush.
4. irq=1 one cycle during a POP -> POP(2), RESUME (pc_load=1, flush=00011), IDLE, irq_ack pulse, PUSH_I(2), VEC (vec_load=1), IDLE.
5. ret_req and call_req both high in IDLE -> POP chosen; after RESUME with call_req still high -> PUSH_C.
6. reset asserted in the second PUSH_I cycle -> next cycle busy=0, push_en=0, irq_pend=0, no vec_load.
